debug_probe: RTL and testbench

- Parametrised successor to the tag's fixed 16-entry serial debug register viewer.
- Scans NPROBES internal signals out serially, one bit per externally supplied debug_clk rising edge.
- debug_clk is treated as an asynchronous strobe, synchronised into the single clk domain.
- Two modes: live, and triggered snapshot with arm/trigger sequencing. Snapshot mode freezes all probes on one cycle, so the debugger sees a coherent view of controller state.

---
 rtl/debug_probe.sv | 145 ++++++++++++++
 tb/tb_debug_probe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_probe.sv
// Serial debug register viewer: scans NPROBES internal signals out one bit
// per debug_clk rising edge, either live or from a triggered snapshot that
// freezes every probe on a single clk cycle.
module debug_probe #(
    parameter int unsigned NPROBES     = 16,
    parameter int unsigned ADDRW       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NPROBES-1:0] probes,
    input  logic               debug_clk,
    input  logic               debug_mode,
    input  logic               arm,
    input  logic               trig_in,
    output logic               debug_out,
    output logic               frame_start,
    output logic               captured,
    output logic [ADDRW-1:0]   scan_addr
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPT
    } state_t;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NPROBES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic [SYNC_STAGES-1:0] trig_sync;
    logic                   dclk_hist;
    logic                   trig_hist;
    logic                   shift_pulse;
    logic                   trig_pulse;
    logic [ADDRW-1:0]       addr;
    logic [ADDRW-1:0]       addr_next;
    logic [NPROBES-1:0]     snap;
    logic                   capture;
    logic                   addr_clear;

    // Synchronise the asynchronous strobes and keep one history flop each
    // so a rising edge yields a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dclk_sync <= '0;
            trig_sync <= '0;
            dclk_hist <= 1'b0;
            trig_hist <= 1'b0;
        end else begin
            dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], debug_clk};
            trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig_in};
            dclk_hist <= dclk_sync[SYNC_STAGES-1];
            trig_hist <= trig_sync[SYNC_STAGES-1];
        end
    end

    assign shift_pulse = dclk_sync[SYNC_STAGES-1] & ~dclk_hist;
    assign trig_pulse  = trig_sync[SYNC_STAGES-1] & ~trig_hist;

    // Snapshot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot sequencing: a trigger while armed beats a coincident arm.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        addr_clear = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = ARMED;
                    addr_clear = 1'b1;
                end
            end
            ARMED: begin
                if (trig_pulse) begin
                    state_next = CAPT;
                    capture    = 1'b1;
                end else if (arm) begin
                    addr_clear = 1'b1;
                end
            end
            CAPT: begin
                if (arm) begin
                    state_next = ARMED;
                    addr_clear = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next scan address: arm clear beats shift; wraps after the last probe.
    always_comb begin
        addr_next = addr;
        if (addr_clear) begin
            addr_next = '0;
        end else if (shift_pulse) begin
            if (addr == LAST_ADDR) begin
                addr_next = '0;
            end else begin
                addr_next = addr + ADDRW'(1);
            end
        end
    end

    // Address counter and snapshot storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            snap <= '0;
        end else begin
            addr <= addr_next;
            if (capture) begin
                snap <= probes;
            end
        end
    end

    // Registered outputs; data and frame marker follow the address by one
    // edge so they always describe the same scan position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debug_out   <= 1'b0;
            frame_start <= 1'b1;
            captured    <= 1'b0;
        end else begin
            debug_out   <= debug_mode ? snap[addr] : probes[addr];
            frame_start <= (addr == '0);
            captured    <= (state_next == CAPT);
        end
    end

    assign scan_addr = addr;

endmodule

// File: tb/tb_debug_probe.sv
// Self-checking bench for debug_probe: table-driven live scan, wrap with a
// 10-probe instance, snapshot corner sequences, and a randomized run
// against a transaction-level reference model.
module tb_debug_probe;

    logic        clk;
    logic        reset;
    logic [15:0] probes;
    logic [9:0]  probes10;
    logic        debug_clk;
    logic        debug_mode;
    logic        arm;
    logic        trig_in;
    logic        debug_out;
    logic        frame_start;
    logic        captured;
    logic [3:0]  scan_addr;
    logic        debug_out10;
    logic        frame_start10;
    logic        captured10;
    logic [3:0]  scan_addr10;

    int unsigned n_checks;
    int unsigned n_pass;

    typedef struct {
        logic [3:0] addr;
        logic       bit_v;
        logic       frame;
    } scan_vec_t;

    scan_vec_t live_tbl [16];

    assign probes10 = probes[9:0];

    debug_probe #(.NPROBES(16), .ADDRW(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .probes      (probes),
        .debug_clk   (debug_clk),
        .debug_mode  (debug_mode),
        .arm         (arm),
        .trig_in     (trig_in),
        .debug_out   (debug_out),
        .frame_start (frame_start),
        .captured    (captured),
        .scan_addr   (scan_addr)
    );

    debug_probe #(.NPROBES(10), .ADDRW(4), .SYNC_STAGES(2)) dut10 (
        .clk         (clk),
        .reset       (reset),
        .probes      (probes10),
        .debug_clk   (debug_clk),
        .debug_mode  (debug_mode),
        .arm         (arm),
        .trig_in     (trig_in),
        .debug_out   (debug_out10),
        .frame_start (frame_start10),
        .captured    (captured10),
        .scan_addr   (scan_addr10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        debug_clk = 1'b0;
        trig_in   = 1'b0;
        arm       = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pulse_dclk(input int unsigned hi, input int unsigned lo);
        debug_clk = 1'b1;
        repeat (hi) tick();
        debug_clk = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic pulse_trig();
        trig_in = 1'b1;
        repeat (5) tick();
        trig_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Scan a whole frame starting at address 0 and compare each bit.
    task automatic scan_frame(input logic [15:0] exp, input string name);
        int unsigned a;
        check({name, " addr0"}, 32'(scan_addr), 32'd0);
        check({name, " bit0"}, 32'(debug_out), 32'(exp[0]));
        for (int unsigned i = 1; i <= 16; i++) begin
            pulse_dclk(4, 4);
            a = i % 16;
            check({name, " addr"}, 32'(scan_addr), a);
            check({name, " bit"}, 32'(debug_out), 32'(exp[a]));
            check({name, " frame"}, 32'(frame_start), 32'(a == 0));
        end
    endtask

    initial begin
        logic [15:0] live_pat;
        logic [9:0]  pat10;
        int unsigned prv;
        int unsigned idx;
        int unsigned a;
        // reference model state
        int unsigned m_addr;
        logic        m_armed;
        logic        m_have;
        logic [15:0] m_snap;
        logic        m_mode;
        int unsigned op;

        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        probes     = 16'hA5C3;
        debug_clk  = 1'b0;
        debug_mode = 1'b0;
        arm        = 1'b0;
        trig_in    = 1'b0;

        live_pat = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            live_tbl[i].addr  = 4'(i);
            live_tbl[i].bit_v = live_pat[i];
            live_tbl[i].frame = (i == 0);
        end

        // ---- reset values and live scan with latency ----
        repeat (2) tick();
        check("rst debug_out", 32'(debug_out), 32'd0);
        check("rst frame", 32'(frame_start), 32'd1);
        check("rst captured", 32'(captured), 32'd0);
        check("rst addr", 32'(scan_addr), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("live addr0", 32'(scan_addr), 32'(live_tbl[0].addr));
        check("live bit0", 32'(debug_out), 32'(live_tbl[0].bit_v));
        check("live frame0", 32'(frame_start), 32'(live_tbl[0].frame));
        for (int unsigned i = 1; i <= 16; i++) begin
            idx = i % 16;
            prv = i - 1;
            debug_clk = 1'b1;
            repeat (2) tick();
            check("lat addr hold", 32'(scan_addr), 32'(live_tbl[prv].addr));
            tick();
            check("lat addr new", 32'(scan_addr), 32'(live_tbl[idx].addr));
            check("lat bit hold", 32'(debug_out), 32'(live_tbl[prv].bit_v));
            tick();
            check("live bit", 32'(debug_out), 32'(live_tbl[idx].bit_v));
            check("live frame", 32'(frame_start), 32'(live_tbl[idx].frame));
            repeat (4) tick();
            debug_clk = 1'b0;
            repeat (8) tick();
        end

        // ---- wrap on a 10-probe instance ----
        probes = 16'h02D5;
        pat10  = 10'h2D5;
        do_reset();
        for (int unsigned i = 1; i <= 25; i++) begin
            pulse_dclk(4, 4);
            a = i % 10;
            check("wrap addr", 32'(scan_addr10), a);
            check("wrap range", 32'(scan_addr10 < 4'd10), 32'd1);
            check("wrap frame", 32'(frame_start10), 32'(a == 0));
            check("wrap bit", 32'(debug_out10), 32'(pat10[a]));
        end
        check("wrap captured", 32'(captured10), 32'd0);

        // ---- snapshot capture ----
        probes     = 16'h0000;
        debug_mode = 1'b1;
        do_reset();
        pulse_arm();
        probes = 16'h1234;
        tick();
        pulse_trig();
        probes = 16'hFFFF;
        repeat (2) tick();
        check("snap captured", 32'(captured), 32'd1);
        scan_frame(16'h1234, "snap");
        pulse_trig();
        check("snap retrig captured", 32'(captured), 32'd1);
        scan_frame(16'h1234, "snap held");

        // ---- re-arm from CAPTURED at addr 7 ----
        repeat (7) pulse_dclk(4, 4);
        check("rearm pre addr", 32'(scan_addr), 32'd7);
        pulse_arm();
        check("rearm captured", 32'(captured), 32'd0);
        check("rearm addr", 32'(scan_addr), 32'd0);

        // ---- arm coincident with trig_pulse while ARMED ----
        probes  = 16'h0F0F;
        trig_in = 1'b1;
        repeat (2) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm+trig captured", 32'(captured), 32'd1);
        repeat (3) tick();
        trig_in = 1'b0;
        probes  = 16'h0000;
        repeat (4) tick();
        scan_frame(16'h0F0F, "arm+trig snap");

        // ---- arm coincident with shift_pulse ----
        repeat (3) pulse_dclk(4, 4);
        check("arm+shift pre addr", 32'(scan_addr), 32'd3);
        debug_clk = 1'b1;
        repeat (2) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm+shift addr", 32'(scan_addr), 32'd0);
        check("arm+shift captured", 32'(captured), 32'd0);
        repeat (5) tick();
        debug_clk = 1'b0;
        repeat (4) tick();
        check("arm+shift addr settled", 32'(scan_addr), 32'd0);

        // ---- trigger while IDLE ----
        probes     = 16'hFFFF;
        debug_mode = 1'b1;
        do_reset();
        pulse_trig();
        check("idle trig captured", 32'(captured), 32'd0);
        check("idle trig bit", 32'(debug_out), 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            pulse_dclk(4, 4);
            check("idle trig scan bit", 32'(debug_out), 32'd0);
        end

        // ---- asynchronous reset in CAPTURED at addr 5 ----
        probes = 16'hBEEF;
        do_reset();
        pulse_arm();
        pulse_trig();
        repeat (5) pulse_dclk(4, 4);
        check("midrst pre addr", 32'(scan_addr), 32'd5);
        check("midrst pre bit", 32'(debug_out), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("midrst debug_out", 32'(debug_out), 32'd0);
        check("midrst frame", 32'(frame_start), 32'd1);
        check("midrst captured", 32'(captured), 32'd0);
        check("midrst addr", 32'(scan_addr), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- randomized operations against a transaction-level model ----
        debug_mode = 1'b0;
        probes     = 16'($urandom);
        do_reset();
        m_addr  = 0;
        m_armed = 1'b0;
        m_have  = 1'b0;
        m_snap  = 16'h0000;
        m_mode  = 1'b0;
        for (int unsigned n = 0; n < 80; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    pulse_dclk(4, 4);
                    m_addr = (m_addr + 1) % 16;
                end
                2: begin
                    pulse_arm();
                    m_armed = 1'b1;
                    m_have  = 1'b0;
                    m_addr  = 0;
                end
                3: begin
                    pulse_trig();
                    if (m_armed) begin
                        m_armed = 1'b0;
                        m_have  = 1'b1;
                        m_snap  = probes;
                    end
                end
                4: begin
                    probes = 16'($urandom);
                end
                default: begin
                    m_mode     = ~m_mode;
                    debug_mode = m_mode;
                end
            endcase
            repeat (2) tick();
            check("rand addr", 32'(scan_addr), m_addr);
            check("rand bit", 32'(debug_out), 32'(m_mode ? m_snap[m_addr] : probes[m_addr]));
            check("rand frame", 32'(frame_start), 32'(m_addr == 0));
            check("rand captured", 32'(captured), 32'(m_have));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
